// File: rtl/messbauer_channel_sequencer.sv
// Dwell/channel/cycle timing front end for messbauer_camac_accumulator.
// Define EXT_SYNC_EN to arm on, and force early wraps from, the external velocity sync.
module messbauer_channel_sequencer #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned CYC_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [ADDR_W-1:0]  last_ch,
  input  logic               det_in,
  input  logic               ext_sync,
  output logic               start,
  output logic               chanel,
  output logic               count,
  output logic [ADDR_W-1:0]  channel_idx,
  output logic [CYC_W-1:0]   cycles,
  output logic               busy
);

  localparam logic [DWELL_W-1:0] DwellOne = DWELL_W'(1);
  localparam logic [ADDR_W-1:0]  AddrOne  = ADDR_W'(1);
  localparam logic [CYC_W-1:0]   CycOne   = CYC_W'(1);

  typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic               start_q, start_d;
  logic               chanel_q, chanel_d;
  logic               count_q, count_d;
  logic               det_s1_q, det_s2_q, det_prev_q;
  logic               det_edge;
  logic [DWELL_W-1:0] dwell_last;
  logic [CYC_W-1:0]   cycles_inc;
  logic               arm_go;
  logic               early_wrap;

`ifdef EXT_SYNC_EN
  logic sync_s1_q, sync_s2_q, sync_prev_q;
  logic sync_edge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_s1_q   <= 1'b0;
      sync_s2_q   <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_s1_q   <= ext_sync;
      sync_s2_q   <= sync_s1_q;
      sync_prev_q <= sync_s2_q;
    end
  end

  assign sync_edge  = sync_s2_q & ~sync_prev_q;
  assign arm_go     = sync_edge;
  assign early_wrap = sync_edge && (idx_q != last_ch);
`else
  logic unused_ext_sync;
  assign unused_ext_sync = ext_sync;
  assign arm_go          = 1'b1;
  assign early_wrap      = 1'b0;
`endif

  assign det_edge   = det_s2_q & ~det_prev_q;
  // A dwell of 0 behaves as 1 clock per channel.
  assign dwell_last = (dwell == '0) ? '0 : dwell - DwellOne;
  assign cycles_inc = (cycles_q == {CYC_W{1'b1}}) ? cycles_q : cycles_q + CycOne;

  always_comb begin
    state_d     = state_q;
    dwell_cnt_d = dwell_cnt_q;
    idx_d       = idx_q;
    cycles_d    = cycles_q;
    start_d     = 1'b0;
    chanel_d    = 1'b0;
    count_d     = det_edge && (state_q == StRun) && enable;

    case (state_q)
      StIdle: begin
        idx_d       = '0;
        dwell_cnt_d = '0;
        if (enable) state_d = StArm;
      end
      StArm: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (arm_go) begin
          state_d     = StRun;
          start_d     = 1'b1;
          idx_d       = '0;
          dwell_cnt_d = '0;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d     = StIdle;
          idx_d       = '0;
          dwell_cnt_d = '0;
        end else if (early_wrap) begin
          idx_d       = '0;
          dwell_cnt_d = '0;
          start_d     = 1'b1;
          cycles_d    = cycles_inc;
        end else if (dwell_cnt_q == dwell_last) begin
          chanel_d    = 1'b1;
          dwell_cnt_d = '0;
          if (idx_q == last_ch) begin
            idx_d    = '0;
            start_d  = 1'b1;
            cycles_d = cycles_inc;
          end else begin
            // Free increment: an index above a lowered last_ch wraps through all-ones.
            idx_d = idx_q + AddrOne;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DwellOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      dwell_cnt_q <= '0;
      idx_q       <= '0;
      cycles_q    <= '0;
      start_q     <= 1'b0;
      chanel_q    <= 1'b0;
      count_q     <= 1'b0;
      det_s1_q    <= 1'b0;
      det_s2_q    <= 1'b0;
      det_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
      idx_q       <= idx_d;
      cycles_q    <= cycles_d;
      start_q     <= start_d;
      chanel_q    <= chanel_d;
      count_q     <= count_d;
      det_s1_q    <= det_in;
      det_s2_q    <= det_s1_q;
      det_prev_q  <= det_s2_q;
    end
  end

  assign start       = start_q;
  assign chanel      = chanel_q;
  assign count       = count_q;
  assign channel_idx = idx_q;
  assign cycles      = cycles_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_messbauer_channel_sequencer.sv
// Self-checking bench: vector table, hand sequences and random stimulus against a timeline model.
module tb_messbauer_channel_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] dwell = 16'd4;
  logic [11:0] last_ch = 12'd2;
  logic        det_in = 1'b0;
  logic        ext_sync = 1'b0;
  logic        start, chanel, count, busy;
  logic [11:0] channel_idx;
  logic [15:0] cycles;

  int n_checks = 0;
  int n_errors = 0;

`ifdef EXT_SYNC_EN
  localparam bit Ext = 1'b1;
`else
  localparam bit Ext = 1'b0;
`endif

  messbauer_channel_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .dwell       (dwell),
    .last_ch     (last_ch),
    .det_in      (det_in),
    .ext_sync    (ext_sync),
    .start       (start),
    .chanel      (chanel),
    .count       (count),
    .channel_idx (channel_idx),
    .cycles      (cycles),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 armed, 2 running; elapsed clocks within the channel.
  int m_mode, m_elapsed, m_idx, m_cyc;
  bit m_start, m_chanel, m_count;
  bit dh1, dh2, dh3, eh1, eh2, eh3;  // input samples taken 1, 2, 3 edges ago

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic bump_cycles();
    if (m_cyc < 65535) m_cyc++;
  endtask

  task automatic model_step();
    bit de, ee;
    int period;
    if (!rst) begin
      m_mode = 0; m_elapsed = 0; m_idx = 0; m_cyc = 0;
      m_start = 0; m_chanel = 0; m_count = 0;
      {dh1, dh2, dh3, eh1, eh2, eh3} = '0;
      return;
    end
    de = dh2 && !dh3;
    ee = eh2 && !eh3;
    m_count  = de && (m_mode == 2) && enable;
    m_start  = 0;
    m_chanel = 0;
    if (m_mode == 0) begin
      m_idx = 0; m_elapsed = 0;
      if (enable) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!enable) m_mode = 0;
      else if (!Ext || ee) begin
        m_mode = 2; m_start = 1; m_idx = 0; m_elapsed = 0;
      end
    end else begin
      period = (dwell == 0) ? 1 : int'(dwell);
      if (!enable) begin
        m_mode = 0; m_idx = 0; m_elapsed = 0;
      end else if (Ext && ee && m_idx != int'(last_ch)) begin
        m_idx = 0; m_elapsed = 0; m_start = 1; bump_cycles();
      end else begin
        m_elapsed = (m_elapsed + 1) % 65536;
        if (m_elapsed == period) begin
          m_elapsed = 0; m_chanel = 1;
          if (m_idx == int'(last_ch)) begin
            m_idx = 0; m_start = 1; bump_cycles();
          end else begin
            m_idx = (m_idx + 1) % 4096;
          end
        end
      end
    end
    {dh3, dh2, dh1} = {dh2, dh1, det_in};
    {eh3, eh2, eh1} = {eh2, eh1, ext_sync};
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("start", 32'(start), 32'(m_start));
    chk("chanel", 32'(chanel), 32'(m_chanel));
    chk("count", 32'(count), 32'(m_count));
    chk("channel_idx", 32'(channel_idx), m_idx);
    chk("cycles", 32'(cycles), m_cyc);
    chk("busy", 32'(busy), (m_mode != 0) ? 1 : 0);
  endtask

  task automatic arm();
    bit seen = 0;
    enable = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      ext_sync = (i >= 1 && i < 4);
      cyc();
      if (start) seen = 1;
    end
    ext_sync = 1'b0;
    chk("arm_start_seen", 32'(seen), 1);
  endtask

  typedef struct {
    bit rst; bit en; int dw; int lc; bit det; bit ext;
    bit e_start; bit e_chanel; int e_idx; int e_cyc; bit e_busy;
  } vec_t;

  initial begin
    vec_t tbl[17];
    int pulses, at, chanels;
    bit seen;

    tbl[0]  = '{1'b0, 1'b1, 4, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 4, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1};
    for (int i = 4; i < 17; i++) tbl[i] = '{1'b1, 1'b1, 4, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    for (int i = 7; i < 11; i++) tbl[i].e_idx = 1;
    for (int i = 11; i < 15; i++) tbl[i].e_idx = 2;
    tbl[7].e_chanel  = 1'b1;
    tbl[11].e_chanel = 1'b1;
    tbl[15].e_chanel = 1'b1;
    tbl[15].e_start  = 1'b1;
    tbl[15].e_cyc    = 1;
    tbl[16].e_cyc    = 1;

`ifdef EXT_SYNC_EN
    rst = 1'b0; enable = 1'b1; det_in = 1'b1; ext_sync = 1'b1;
    cyc(); cyc();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_cycles", 32'(cycles), 0);
    rst = 1'b1; enable = 1'b0; det_in = 1'b0; ext_sync = 1'b0;
    cyc();
    arm();
`else
    foreach (tbl[i]) begin
      rst = tbl[i].rst; enable = tbl[i].en; dwell = 16'(tbl[i].dw);
      last_ch = 12'(tbl[i].lc); det_in = tbl[i].det; ext_sync = tbl[i].ext;
      cyc();
      chk($sformatf("tbl%0d_start", i), 32'(start), 32'(tbl[i].e_start));
      chk($sformatf("tbl%0d_chanel", i), 32'(chanel), 32'(tbl[i].e_chanel));
      chk($sformatf("tbl%0d_idx", i), 32'(channel_idx), tbl[i].e_idx);
      chk($sformatf("tbl%0d_cycles", i), 32'(cycles), tbl[i].e_cyc);
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
    end
`endif

    // Held detector: one count, on the 3rd edge after det_in rises.
    pulses = 0; at = -1;
    for (int k = 0; k < 15; k++) begin
      det_in = (k < 10);
      cyc();
      if (count) begin pulses++; at = k; end
    end
    chk("det_held_pulses", pulses, 1);
    chk("det_held_latency", at, 2);

    // Detector activity while idle is discarded.
    enable = 1'b0;
    cyc();
    chk("drop_busy", 32'(busy), 0);
    chk("drop_idx", 32'(channel_idx), 0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      det_in = (k < 2);
      cyc();
      if (count) pulses++;
    end
    chk("idle_det_pulses", pulses, 0);

    // Enable drops in the middle of channel 1.
    dwell = 16'd4; last_ch = 12'd2;
    arm();
    for (int k = 0; k < 6; k++) cyc();
    chk("mid_ch1_idx", 32'(channel_idx), 1);
    enable = 1'b0;
    cyc();
    chk("stop_busy", 32'(busy), 0);
    chk("stop_idx", 32'(channel_idx), 0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (chanel || start) pulses++;
    end
    chk("stop_no_pulses", pulses, 0);

`ifdef EXT_SYNC_EN
    // External sync in channel 1 of a 6-channel spectrum forces an early wrap.
    dwell = 16'd4; last_ch = 12'd5;
    arm();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      if (channel_idx == 12'd1) seen = 1;
    end
    at = m_cyc;
    ext_sync = 1'b1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cyc();
      if (start) seen = 1;
    end
    ext_sync = 1'b0;
    chk("ext_wrap_seen", 32'(seen), 1);
    chk("ext_wrap_chanel", 32'(chanel), 0);
    chk("ext_wrap_idx", 32'(channel_idx), 0);
    chk("ext_wrap_cycles", 32'(cycles), at + 1);
    enable = 1'b0;
    cyc();
`endif

    // dwell=0, last_ch=0: every clock is a channel end and a spectrum start.
    dwell = 16'd0; last_ch = 12'd0;
    arm();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("d0_chanel", 32'(chanel), 1);
      chk("d0_start", 32'(start), 1);
    end
    for (int k = 0; k < 65540; k++) cyc();
    chk("cycles_saturated", 32'(cycles), 65535);
    cyc();
    chk("cycles_held_sat", 32'(cycles), 65535);
    chk("sat_still_starts", 32'(start), 1);

    // last_ch lowered beneath the index: wraps through all-ones, no lockup.
    enable = 1'b0;
    cyc();
    dwell = 16'd1; last_ch = 12'd5;
    arm();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      if (channel_idx == 12'd4) seen = 1;
    end
    chk("reach_idx4", 32'(seen), 1);
    last_ch = 12'd2;
    chanels = 0; seen = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      cyc();
      if (chanel) chanels++;
      if (start) seen = 1;
    end
    chk("lowered_wrap_seen", 32'(seen), 1);
    chk("lowered_wrap_chanels", chanels, 4095);

    // Randomised traffic; dwell/last_ch only change while disabled.
    enable = 1'b0;
    cyc();
    for (int i = 0; i < 3000; i++) begin
      if (!enable) begin
        dwell   = 16'($urandom_range(0, 5));
        last_ch = 12'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      det_in = ($urandom_range(0, 3) == 0);
      if (Ext && $urandom_range(0, 15) == 0) ext_sync = ~ext_sync;
      cyc();
    end

    // Reset while running clears everything on that edge.
    enable = 1'b1; dwell = 16'd2; last_ch = 12'd1;
    arm();
    for (int k = 0; k < 5; k++) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_run_busy", 32'(busy), 0);
    chk("rst_run_idx", 32'(channel_idx), 0);
    chk("rst_run_cycles", 32'(cycles), 0);
    chk("rst_run_start", 32'(start), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/messbauer_channel_sequencer.md
Name: messbauer_channel_sequencer

Overview:
Upstream timing stage for messbauer_camac_accumulator. Generates the `start` (spectrum-cycle begin), `chanel` (channel advance) and `count` (detector event) single-clock pulses that the accumulator consumes. Dwell time per velocity channel and spectrum length are programmable. Asynchronous detector and external velocity-sync inputs are synchronised and edge-detected here, so the accumulator sees clean one-cycle pulses only.

Parameters:
DWELL_W, 16, width of dwell-time register in clocks
ADDR_W, 12, width of channel index (matches accumulator address)
CYC_W, 16, width of completed-cycle counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on next clk edge)
enable  in  1  run request; level-sensitive
dwell  in  DWELL_W  clocks per channel; 0 treated as 1
last_ch  in  ADDR_W  index of last channel in spectrum (channels 0..last_ch)
det_in  in  1  asynchronous detector pulse, active-high
ext_sync  in  1  asynchronous velocity-drive sync, active-high
start  out  1  1-clk pulse at channel 0 of every cycle
chanel  out  1  1-clk pulse at end of each channel dwell
count  out  1  1-clk pulse per detector rising edge while running
channel_idx  out  ADDR_W  current channel
cycles  out  CYC_W  completed spectrum cycles, saturating
busy  out  1  high in ARM or RUN

Behaviour:
- Reset: state=IDLE; start=chanel=count=0; channel_idx=0; cycles=0; busy=0; sync flops=0; dwell_cnt=0.
- Synchronisers: det_in and ext_sync each go through 2 flops plus a previous-value flop. Rising edge = s2 & ~prev. `count` is registered: high on the 3rd clk edge after det_in is first sampled high, for exactly 1 clk. Held-high input gives one pulse only.
- FSM states: IDLE, ARM, RUN.
- IDLE: outputs idle, busy=0. If enable=1, go to ARM.
- ARM: busy=1. Wait for ext_sync rising edge, then go to RUN. If enable=0, go to IDLE.
- RUN entry clk: start=1, channel_idx=0, dwell_cnt=0.
- RUN, each clk: dwell_cnt+1. When dwell_cnt==max(dwell,1)-1:
  - chanel=1 and dwell_cnt=0.
  - If channel_idx==last_ch: channel_idx=0, start=1 in the same clk as chanel, and cycles+1 (saturates at all-ones).
  - Otherwise channel_idx+1.
- Pulse spacing: with dwell=D, chanel pulses are D clks apart. The first chanel comes D clks after the start pulse.
- dwell and last_ch are sampled live. A change takes effect from the next comparison. If last_ch is lowered below channel_idx, the index runs until it wraps at all-ones, then resumes normally (no lockup).
- count in RUN only; edges in IDLE/ARM are discarded. A count coinciding with chanel or start is still emitted in that clk.
- enable=0 in RUN: next clk go to IDLE, channel_idx=0, no further pulses. A pulse already registered in that clk completes. cycles is held and cleared only by reset.
- Reset mid-RUN: all outputs return to reset values on that clk edge.
- last_ch=0: every chanel is also a start, and cycles increments every dwell.

Optional Feature:
EXT_SYNC_EN
- Defined: ARM waits for ext_sync edge (above). In RUN, an ext_sync edge arriving when channel_idx!=last_ch forces an early wrap: channel_idx=0, dwell_cnt=0, start=1, cycles+1, no chanel pulse.
- Undefined: ext_sync is ignored and its synchroniser is removed. ARM lasts exactly one clk, then enters RUN. Cycles are free-running on the internal dwell timer.

Test Plan:
- rst=0 for 2 clk with all inputs high -> all outputs 0, state IDLE, cycles=0.
- enable=1, dwell=4, last_ch=2, ext_sync edge -> start at RUN entry, then chanel every 4 clk with channel_idx 0→1→2→0. Start coincides with the 3rd chanel; cycles=1 after 12 clk.
- RUN, det_in high for 10 clk -> exactly one count pulse, 3 clk after det_in goes high. det_in pulse during IDLE -> no count.
- dwell=0, last_ch=0 -> chanel and start every clk; cycles increments every clk. Force cycles near max -> saturates at 16'hFFFF.
- enable drops mid-channel 1 -> IDLE next clk, channel_idx=0, busy=0, no more chanel pulses.
- With EXT_SYNC_EN: ext_sync edge at channel_idx=1 of last_ch=5 -> channel_idx=0, start=1, chanel=0, cycles+1.
